// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared state encoding and constants for the MII receive path
package eth_rx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA_LO, DATA_HI, DROP} rx_state_t;
  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE = 4'hD;
  localparam int DEFAULT_MAX_FRAME_BYTES = 1522;
endpackage

// File: rtl/mii_rx_byte_assembler.sv
// mii_rx_byte_assembler: strips preamble/SFD, packs nibbles into framed bytes, counts frames
module mii_rx_byte_assembler
  import eth_rx_pkg::*;
#(
  parameter int PREAMBLE_MIN_NIBBLES = 2,
  parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 rxDvIn,
  input  logic                 rxErIn,
  input  logic [3:0]           rxDIn,
  output logic [7:0]           dataOut,
  output logic                 validOut,
  output logic                 sofOut,
  output logic                 eofOut,
  output logic                 errOut,
  output logic [CNT_WIDTH-1:0] frameCntOut,
  output logic [CNT_WIDTH-1:0] errCntOut
);
  localparam int PW = $clog2(PREAMBLE_MIN_NIBBLES + 1);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  rx_state_t state, state_n;
  logic [PW-1:0] pre_cnt, pre_n;
  logic [BW-1:0] byte_cnt, bcnt_n;
  logic [3:0] lo, lo_n;
  logic [7:0] hold, hold_n, data_n;
  logic full, full_n, sof_pend, sofp_n, err_flag, errf_n;
  logic valid_n, sof_n, eof_n, err_n;
  // Output lags one byte: each byte waits in hold until we know whether it is the last
  always_comb begin
    state_n = state;
    pre_n = pre_cnt;
    bcnt_n = byte_cnt;
    lo_n = lo;
    hold_n = hold;
    full_n = full;
    sofp_n = sof_pend;
    errf_n = err_flag;
    data_n = hold;
    valid_n = 1'b0;
    sof_n = 1'b0;
    eof_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (rxDvIn) begin
        state_n = (rxDIn == PREAMBLE_NIBBLE) ? PREAMBLE : DROP;
        pre_n = PW'(1);
      end
      PREAMBLE:
        if (!rxDvIn) state_n = IDLE;
        else if (rxDIn == PREAMBLE_NIBBLE)
          pre_n = (pre_cnt == PW'(PREAMBLE_MIN_NIBBLES)) ? pre_cnt : pre_cnt + 1'b1;
        else if (rxDIn == SFD_NIBBLE && pre_cnt == PW'(PREAMBLE_MIN_NIBBLES)) begin
          state_n = DATA_LO;
          bcnt_n = '0;
          sofp_n = 1'b1;
          errf_n = 1'b0;
          full_n = 1'b0;
        end else state_n = DROP;
      DATA_LO: begin
        errf_n = err_flag | rxErIn;
        if (rxDvIn) begin
          lo_n = rxDIn;
          state_n = DATA_HI;
        end else begin
          valid_n = full;
          sof_n = full & sof_pend;
          eof_n = full;
          err_n = full & err_flag;
          full_n = 1'b0;
          state_n = IDLE;
        end
      end
      DATA_HI: begin
        errf_n = err_flag | rxErIn;
        valid_n = full;
        sof_n = full & sof_pend;
        if (!rxDvIn || byte_cnt == BW'(MAX_FRAME_BYTES)) begin
          eof_n = full;
          err_n = full;
          full_n = 1'b0;
          state_n = rxDvIn ? DROP : IDLE;
        end else begin
          sofp_n = sof_pend & ~full;
          hold_n = {rxDIn, lo};
          full_n = 1'b1;
          bcnt_n = byte_cnt + 1'b1;
          state_n = DATA_LO;
        end
      end
      DROP: if (!rxDvIn) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state <= IDLE;
      pre_cnt <= '0;
      byte_cnt <= '0;
      lo <= '0;
      hold <= '0;
      full <= 1'b0;
      sof_pend <= 1'b0;
      err_flag <= 1'b0;
      dataOut <= '0;
      validOut <= 1'b0;
      sofOut <= 1'b0;
      eofOut <= 1'b0;
      errOut <= 1'b0;
      frameCntOut <= '0;
      errCntOut <= '0;
    end else begin
      state <= state_n;
      pre_cnt <= pre_n;
      byte_cnt <= bcnt_n;
      lo <= lo_n;
      hold <= hold_n;
      full <= full_n;
      sof_pend <= sofp_n;
      err_flag <= errf_n;
      dataOut <= data_n;
      validOut <= valid_n;
      sofOut <= sof_n;
      eofOut <= eof_n;
      errOut <= err_n;
      if (eof_n && ~&frameCntOut) frameCntOut <= frameCntOut + 1'b1;
      if (eof_n && err_n && ~&errCntOut) errCntOut <= errCntOut + 1'b1;
    end
  end
endmodule

// File: doc/mii_rx_byte_assembler.md
Name: mii_rx_byte_assembler

Overview:
Downstream stage of the MII receive input pipe: it consumes the registered rx_dv / rx_er / rxd[3:0] nibble stream and strips the preamble and SFD. It assembles nibbles into bytes and emits a byte stream with start, end and error framing to the Ethernet parser. Everything runs on one clock, the MII receive clock, at one nibble per cycle, with no backpressure. It also keeps per-frame statistics counters.

Parameters:
PREAMBLE_MIN_NIBBLES, 2, minimum count of 0x5 nibbles, including the SFD low nibble, required before the 0xD nibble.
MAX_FRAME_BYTES, 1522, byte count above which the frame is truncated and flagged as an error.
CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
clkIn, input, 1, MII rx clock; the only clock.
rstIn, input, 1, synchronous, active-high reset.
rxDvIn, input, 1, data valid from the input pipe.
rxErIn, input, 1, receive error from the input pipe.
rxDIn, input, 4, data nibble, least-significant nibble first.
dataOut, output, 8, assembled byte.
validOut, output, 1, dataOut is valid this cycle.
sofOut, output, 1, qualifies the first byte after the SFD.
eofOut, output, 1, qualifies the last byte of the frame.
errOut, output, 1, frame error; meaningful only when eofOut is high.
frameCntOut, output, CNT_WIDTH, frames emitted; saturating.
errCntOut, output, CNT_WIDTH, frames emitted with errOut set; saturating.

Behaviour:
- Clock and reset: single clock clkIn; reset rstIn is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0, counters 0, FSM in IDLE, hold register empty. A reset mid-frame drops the frame silently, with no eof.
- FSM states: IDLE, PREAMBLE, DATA_LO, DATA_HI, DROP.
- IDLE:
  - dv=1 and nibble=5 -> PREAMBLE, preamble count=1.
  - dv=1 with any other nibble -> DROP.
- PREAMBLE:
  - dv=0 -> IDLE, no output.
  - nibble=5 -> count++ (saturates).
  - nibble=D and count>=PREAMBLE_MIN_NIBBLES -> DATA_LO, byte count=0, sof pending=1, err flag=0.
  - nibble=D with count too low, or any other nibble -> DROP.
- DROP: stay until dv=0, then go to IDLE. Never produces output.
- DATA_LO:
  - dv=1: latch the low nibble and go to DATA_HI.
  - dv=0: end of frame. If the hold register is full, emit the held byte with eof=1 and err=err flag. If it is empty (zero-byte frame), emit nothing. Then go to IDLE.
- DATA_HI:
  - dv=1: byte = {nibble, low}. If the hold register is full, emit the held byte (sof if pending; clear pending). Load the new byte into the hold register, byte count++, then go to DATA_LO.
  - dv=0 (odd nibble count): emit the held byte if present with eof=1, err=1. If no byte is held, emit nothing. Go to IDLE.
- Latency: the byte whose high nibble is sampled at edge t is presented one byte-time later. It appears on outputs after the edge that samples the next byte's high nibble, or after the edge that samples dv=0.
- Single-byte frame: one output cycle with sof=1 and eof=1 together.
- Error flag: rxErIn=1 while in DATA_LO or DATA_HI sets the err flag. It is reported on that frame's eof.
- Oversize: when byte count would exceed MAX_FRAME_BYTES, emit the held byte with eof=1 and err=1, then go to DROP. No further bytes of that frame are emitted.
- Counters: frameCnt increments on every eof; errCnt increments on eof with err=1. Both hold at all-ones.
- Strobes: validOut, sofOut and eofOut are single-cycle. sofOut and eofOut are never high without validOut.
- Back-to-back frames: one dv=0 cycle between frames is sufficient. The eof of frame k and the preamble of frame k+1 do not interact.

Decomposition:
- Package eth_rx_pkg holds:
  - the state enum rx_state_t;
  - PREAMBLE_NIBBLE=4'h5 and SFD_NIBBLE=4'hD;
  - the default MAX_FRAME_BYTES.
- Single module; no sub-module is warranted. The input pipe is instantiated by the parent, not inside this block.

Test Plan:
- 15×5, D, then bytes 0x01 0x02 0x03 (nibbles 1,0,2,0,3,0), dv low -> three valid cycles, data 01/02/03, sof on 01, eof on 03, err=0, frameCnt=1.
- Preamble 5,5,D, one byte 0xAB, dv low -> single valid cycle with data AB, sof=1, eof=1.
- Preamble + SFD + 0x11, 0x22, then a lone nibble 3, dv low -> 11 with sof, 22 with eof and err=1, errCnt=1.
- Pulse rxErIn mid-payload of a 4-byte frame -> 4 bytes out, err=1 on the last one. Then an IFG of 1 cycle and a clean frame -> second frame err=0, frameCnt=2.
- Preamble nibble 7, or D after a single 5 -> no output; dv low then a valid frame -> the valid frame is received normally.
- MAX_FRAME_BYTES=4 with a 6-byte frame -> bytes 1-4 out, eof+err on byte 4, nothing more until dv low. Separately, assert rstIn mid-frame -> outputs 0 and counters 0, with no eof emitted.
